// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the load/store unit.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } lsu_state_t;

    localparam logic [3:0] LANE_NONE    = 4'b0000;
    localparam logic [3:0] LANE_BYTE0   = 4'b0001;
    localparam logic [3:0] LANE_LO_HALF = 4'b0011;
    localparam logic [3:0] LANE_HI_HALF = 4'b1100;
    localparam logic [3:0] LANE_ALL     = 4'b1111;

    // Alignment and encoding legality; stores have no unsigned variants.
    function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] lanes;
        case (f3)
            F3_B:    lanes = LANE_BYTE0 << off;
            F3_H:    lanes = off[1] ? LANE_HI_HALF : LANE_LO_HALF;
            F3_W:    lanes = LANE_ALL;
            default: lanes = LANE_NONE;
        endcase
        return lanes;
    endfunction

    // Replicate narrow store data across all lanes so the byte enables pick the right copy.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wd[7:0]}};
            F3_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   res = {24'h000000, sh[7:0]};
            F3_HU:   res = {16'h0000, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: byte write enables, registered read with enable.
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes and enabled read; the read port holds its value between loads.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: aligned byte/half/word access to a local data RAM with
// configurable load latency and misalignment rejection.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluout,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        rd_valid,
    output logic        busy,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Last WAIT count value; unused when RD_LAT is 1 since WAIT is never entered.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

    lsu_state_t  state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rd_q;
    logic        mis_q;

    logic        idle;
    logic        store_req, load_req, ok;
    logic        store_go, load_go, reject;
    logic [31:0] ram_word, ext;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^aluout[31:AW+2];

    assign idle      = (state == S_IDLE);
    // A simultaneous read and write is treated as a store alone.
    assign store_req = idle & memwrite;
    assign load_req  = idle & memread & ~memwrite;
    assign ok        = access_ok(memwrite, funct3, aluout[1:0]);
    assign store_go  = store_req & ok;
    assign load_go   = load_req & ok;
    assign reject    = (store_req | load_req) & ~ok;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .addr (aluout[AW+1:2]),
        .we   (store_go ? store_lanes(funct3, aluout[1:0]) : LANE_NONE),
        .wdata(store_data(funct3, wd)),
        .re   (load_go),
        .rdata(ram_word)
    );

    assign ext        = load_extend(f3_q, off_q, ram_word);
    assign misaligned = mis_q;

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state and handshake outputs; rd is live from the RAM during DONE, held otherwise.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = 1'b0;
        rd_valid = 1'b0;
        rd       = rd_q;
        case (state)
            S_IDLE: begin
                if (load_go) begin
                    state_nx = (RD_LAT == 1) ? S_DONE : S_WAIT;
                    cnt_nx   = '0;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt == WAIT_LAST) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 2'd1;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                rd       = ext;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Load attributes captured at accept, result hold register and reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q  <= '0;
            off_q <= '0;
            rd_q  <= '0;
            mis_q <= 1'b0;
        end else begin
            if (load_go) begin
                f3_q  <= funct3;
                off_q <= aluout[1:0];
            end
            if (state == S_DONE) begin
                rd_q <= ext;
            end
            mis_q <= reject;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: two instances (RD_LAT=1 and RD_LAT=3).
module tb_mem_lsu;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  memread, memwrite;
    logic [2:0]  funct3 [2];
    logic [31:0] aluout [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic [1:0]  rd_valid, busy, misaligned;

    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;

    exp_t        q_rd0[$], q_rd1[$];
    int unsigned q_mis0[$], q_mis1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_lsu #(.DEPTH_WORDS(256), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[0]), .memread(memread[0]), .memwrite(memwrite[0]),
        .funct3(funct3[0]), .aluout(aluout[0]), .wd(wd[0]), .rd(rd[0]),
        .rd_valid(rd_valid[0]), .busy(busy[0]), .misaligned(misaligned[0])
    );

    mem_lsu #(.DEPTH_WORDS(256), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]), .memread(memread[1]), .memwrite(memwrite[1]),
        .funct3(funct3[1]), .aluout(aluout[1]), .wd(wd[1]), .rd(rd[1]),
        .rd_valid(rd_valid[1]), .busy(busy[1]), .misaligned(misaligned[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor side: pop expectations whenever a DUT presents a result or a reject pulse.
    task automatic chk_rd(input int i);
        exp_t e;
        int unsigned lat;
        lat = (i == 0) ? 1 : 3;
        total++;
        if ((i == 0 && q_rd0.size() == 0) || (i == 1 && q_rd1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_rd_valid[%0d]: got rd_valid=1 rd=%h want no pulse (cycle %0d)",
                     i, rd[i], cyc);
        end else begin
            e = (i == 0) ? q_rd0.pop_front() : q_rd1.pop_front();
            check($sformatf("rd_data[%0d] lat%0d", i, lat), rd[i], e.data);
            check($sformatf("rd_cycle[%0d]", i), cyc, e.due);
            check($sformatf("busy_with_valid[%0d]", i), 32'(busy[i]), 32'd1);
        end
    endtask

    task automatic chk_mis(input int i);
        int unsigned due;
        total++;
        if ((i == 0 && q_mis0.size() == 0) || (i == 1 && q_mis1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_misaligned[%0d]: got pulse want none (cycle %0d)", i, cyc);
        end else begin
            due = (i == 0) ? q_mis0.pop_front() : q_mis1.pop_front();
            check($sformatf("mis_cycle[%0d]", i), cyc, due);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid[0]) chk_rd(0);
        if (rd_valid[1]) chk_rd(1);
        if (misaligned[0]) chk_mis(0);
        if (misaligned[1]) chk_mis(1);
    end

    // Stimulus side.
    task automatic issue(input int i, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, output int unsigned at);
        @(posedge clk); #1;
        memread[i] = r; memwrite[i] = w; funct3[i] = f3; aluout[i] = a; wd[i] = d;
        at = cyc;
        @(posedge clk); #1;
        memread[i] = 1'b0; memwrite[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy[i] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("idle_timeout[%0d]", i), 32'(busy[i]), 32'd0);
    endtask

    task automatic push_rd(input int i, input logic [31:0] data, input int unsigned due);
        exp_t e;
        e.data = data;
        e.due  = due;
        if (i == 0) q_rd0.push_back(e); else q_rd1.push_back(e);
    endtask

    task automatic store(input int i, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        int unsigned at;
        issue(i, 1'b0, 1'b1, f3, a, d, at);
    endtask

    task automatic load(input int i, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp);
        int unsigned at;
        issue(i, 1'b1, 1'b0, f3, a, 32'h0, at);
        push_rd(i, exp, at + ((i == 0) ? 1 : 3));
        wait_idle(i);
    endtask

    task automatic reject(input int i, input logic r, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        int unsigned at;
        issue(i, r, w, f3, a, d, at);
        if (i == 0) q_mis0.push_back(at + 1); else q_mis1.push_back(at + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned at;
        rst_n = 2'b00; memread = '0; memwrite = '0;
        for (int i = 0; i < 2; i++) begin
            funct3[i] = '0; aluout[i] = '0; wd[i] = '0;
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_rd[%0d]", i), rd[i], 32'h0);
            check($sformatf("reset_rd_valid[%0d]", i), 32'(rd_valid[i]), 32'd0);
            check($sformatf("reset_busy[%0d]", i), 32'(busy[i]), 32'd0);
            check($sformatf("reset_misaligned[%0d]", i), 32'(misaligned[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 2'b11;

        // RD_LAT=1 instance: word access, byte/half extension.
        store(0, F3_W, 32'h0, 32'hAABBCCDD);
        load (0, F3_W, 32'h0, 32'hAABBCCDD);
        store(0, F3_B, 32'h1, 32'h00000011);
        load (0, F3_B,  32'h1, 32'h00000011);
        load (0, F3_BU, 32'h3, 32'h000000AA);
        load (0, F3_B,  32'h3, 32'hFFFFFFAA);
        load (0, F3_H,  32'h2, 32'hFFFFAABB);

        // Rejected accesses must not alter memory or start a load.
        reject(0, 1'b1, 1'b0, F3_W,   32'h2, 32'h0);
        reject(0, 1'b0, 1'b1, F3_H,   32'h1, 32'h0000FFFF);
        reject(0, 1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        reject(0, 1'b0, 1'b1, F3_BU,  32'h0, 32'h00000099);
        load (0, F3_W, 32'h0, 32'hAABB11DD);
        repeat (3) @(posedge clk);
        #1;
        check("rd_hold", rd[0], 32'hAABB11DD);

        // Address wrap modulo depth.
        store(0, F3_W, 32'h400, 32'h12345678);
        load (0, F3_W, 32'h0, 32'h12345678);

        // Read+write together is a store only.
        issue(0, 1'b1, 1'b1, F3_W, 32'h8, 32'hCAFEF00D, at);
        repeat (3) @(posedge clk);
        load (0, F3_W, 32'h8, 32'hCAFEF00D);
        store(0, F3_H, 32'hA, 32'h00008001);
        load (0, F3_HU, 32'hA, 32'h00008001);
        load (0, F3_H,  32'hA, 32'hFFFF8001);
        load (0, F3_W,  32'h8, 32'h8001F00D);

        // RD_LAT=3 instance: latency and stores ignored while busy.
        store(1, F3_W, 32'h0, 32'h55667788);
        store(1, F3_W, 32'h4, 32'h01020304);
        issue(1, 1'b1, 1'b0, F3_W, 32'h0, 32'h0, at);
        push_rd(1, 32'h55667788, at + 3);
        issue(1, 1'b0, 1'b1, F3_W, 32'h4, 32'hDEADBEEF, at);
        wait_idle(1);
        load (1, F3_W, 32'h4, 32'h01020304);

        // Reset in the middle of a load.
        issue(1, 1'b1, 1'b0, F3_W, 32'h0, 32'h0, at);
        @(posedge clk); #1;
        check("busy_before_rst", 32'(busy[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        check("midrst_rd", rd[1], 32'h0);
        check("midrst_rd_valid", 32'(rd_valid[1]), 32'd0);
        check("midrst_busy", 32'(busy[1]), 32'd0);
        check("midrst_misaligned", 32'(misaligned[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (8) @(posedge clk);
        load (1, F3_W, 32'h4, 32'h01020304);

        repeat (5) @(posedge clk);
        #1;
        check("q_rd0_drained",  32'(q_rd0.size()),  32'd0);
        check("q_rd1_drained",  32'(q_rd1.size()),  32'd0);
        check("q_mis0_drained", 32'(q_mis0.size()), 32'd0);
        check("q_mis1_drained", 32'(q_mis1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, data memory depth in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter RD_LAT, default 1, load latency in cycles from accepted request to rd_valid (1..4).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port memread  in  1  load request, sampled when busy=0.
REQ-006 SHALL have port memwrite  in  1  store request, sampled when busy=0.
REQ-007 SHALL have port funct3  in  3  access type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw.
REQ-008 SHALL have port aluout  in  32  byte address.
REQ-009 SHALL have port wd  in  32  store data, low bytes used for sb/sh.
REQ-010 SHALL have port rd  out  32  load result, extended per funct3.
REQ-011 SHALL have port rd_valid  out  1  one-cycle pulse, rd holds a new load result.
REQ-012 SHALL have port busy  out  1  load in flight, new requests ignored.
REQ-013 SHALL have port misaligned  out  1  one-cycle pulse, access rejected.

Function
REQ-014 SHALL index memory by word = aluout[log2(DEPTH_WORDS)+1:2], ignoring higher bits (wrap-around modulo depth).
REQ-015 SHALL perform stores in the accept cycle with byte enables: sb one lane per aluout[1:0], sh lanes 0-1 or 2-3 per aluout[1], sw all four lanes.
REQ-016 SHALL flag misaligned for: lh/lhu/sh with aluout[0]=1, lw/sw with aluout[1:0]!=0, or undefined funct3 (011,110,111, or 1xx on a store); memory SHALL NOT change, no load SHALL start, misaligned SHALL pulse the next cycle.
REQ-017 SHALL use FSM IDLE -> WAIT (RD_LAT-1 cycles, counter) -> DONE -> IDLE for loads; with RD_LAT=1, IDLE -> DONE.
REQ-018 SHALL assert busy in WAIT and DONE; rd_valid SHALL pulse in DONE only.
REQ-019 SHALL latch funct3 and aluout[1:0] at accept and use the latched values for lane select and extension.
REQ-020 SHALL sign-extend lb/lh and zero-extend lbu/lhu; lw passes the word unchanged.
REQ-021 SHALL hold rd stable between rd_valid pulses.
REQ-022 SHALL treat memread=1 with memwrite=1 in IDLE as a store only; read ignored, no flag.
REQ-023 SHALL ignore all requests while busy=1, including stores.
REQ-024 SHALL return store-then-load data to the same address on the next accepted load (no stale read).

Reset
REQ-025 SHALL on rst_n=0 force rd=0, rd_valid=0, busy=0, misaligned=0, FSM IDLE, latency counter 0, immediately and asynchronously.
REQ-026 SHALL abort a load in flight on reset; no rd_valid SHALL follow reset release.
REQ-027 SHALL NOT reset memory contents; contents are undefined until written.

Structure
REQ-028 SHALL place the funct3 encodings, FSM state typedef and byte-lane helper constants in shared package mem_pkg.
REQ-029 SHALL instantiate one sub-module dmem_ram: DEPTH_WORDS x 32 synchronous RAM with 4-bit byte write enable and registered read.

Verification
REQ-030 SHALL check: sw 0xAABBCCDD @0, lw @0 (RD_LAT=1) -> rd=0xAABBCCDD, rd_valid 1 cycle after accept, busy high that cycle.
REQ-031 SHALL check: after REQ-030, sb 0x11 @1, lb @1 -> 0x00000011; lbu @3 -> 0x000000AA; lb @3 -> 0xFFFFFFAA; lh @2 -> 0xFFFFAABB.
REQ-032 SHALL check: lw @2 and sh @1 -> misaligned pulse each, rd_valid never, word @0 still 0xAABB11DD.
REQ-033 SHALL check: RD_LAT=3, lw @0 -> rd_valid exactly 3 cycles after accept; sw @4 issued during busy ignored (lw @4 afterwards returns prior contents).
REQ-034 SHALL check: DEPTH_WORDS=256, sw 0x12345678 @0x400, lw @0 -> 0x12345678 (wrap).
REQ-035 SHALL check: rst_n low mid-load (RD_LAT=3, cycle 2) -> outputs 0 at once, no rd_valid after release; memread+memwrite together -> store performed, no rd_valid.
